// File: rtl/ln_stat_acc.sv
// Row-statistics accumulator for LayerNorm: sums per-beat Σx / Σx² tree outputs
// over a configurable number of beats and emits row totals at row end.
module ln_stat_acc #(
  parameter int SUM_WIDTH = 26,
  parameter int SQ_WIDTH  = 42,
  parameter int CNT_WIDTH = 8,
  parameter int TREE_LAT  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic [CNT_WIDTH-1:0]          i_beats,
  input  logic                          i_vld,
  input  logic [SUM_WIDTH-1:0]          i_sum,
  input  logic [SQ_WIDTH-1:0]           i_sqsum,
  output logic                          o_vld,
  output logic [SUM_WIDTH+CNT_WIDTH-1:0] o_sum,
  output logic [SQ_WIDTH+CNT_WIDTH-1:0]  o_sqsum,
  output logic                          o_busy,
  output logic                          o_err,
  output logic                          o_drop
);

  localparam int AW = SUM_WIDTH + CNT_WIDTH;
  localparam int QW = SQ_WIDTH + CNT_WIDTH;

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

  state_t                state;
  logic [TREE_LAT-1:0]   vld_sr;
  logic                  vld_a;
  logic [CNT_WIDTH-1:0]  beats;
  logic [CNT_WIDTH-1:0]  cnt;
  logic signed [AW-1:0]  acc_sum;
  logic signed [QW-1:0]  acc_sq;
  logic signed [AW-1:0]  sum_ext;
  logic signed [QW-1:0]  sq_ext;
  logic signed [AW-1:0]  sum_nxt;
  logic signed [QW-1:0]  sq_nxt;
  logic                  last_beat;

  assign vld_a     = vld_sr[TREE_LAT-1];
  assign sum_ext   = {{CNT_WIDTH{i_sum[SUM_WIDTH-1]}}, i_sum};
  assign sq_ext    = {{CNT_WIDTH{i_sqsum[SQ_WIDTH-1]}}, i_sqsum};
  assign sum_nxt   = acc_sum + sum_ext;
  assign sq_nxt    = acc_sq + sq_ext;
  assign last_beat = (cnt == (beats - {{(CNT_WIDTH-1){1'b0}}, 1'b1}));
  assign o_busy    = (state == ACC);

  // Valid delay line, row state machine, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      vld_sr  <= '0;
      beats   <= '0;
      cnt     <= '0;
      acc_sum <= '0;
      acc_sq  <= '0;
      o_vld   <= 1'b0;
      o_sum   <= '0;
      o_sqsum <= '0;
      o_err   <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      vld_sr <= (vld_sr << 1) | {{(TREE_LAT-1){1'b0}}, i_vld};
      o_vld  <= 1'b0;
      o_err  <= 1'b0;
      o_drop <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_beats != '0) begin
              beats   <= i_beats;
              cnt     <= '0;
              acc_sum <= '0;
              acc_sq  <= '0;
              state   <= ACC;
            end else begin
              o_err <= 1'b1;
            end
          end
          if (vld_a) begin
            o_drop <= 1'b1;
          end
        end
        ACC: begin
          if (vld_a && last_beat) begin
            o_vld   <= 1'b1;
            o_sum   <= sum_nxt;
            o_sqsum <= sq_nxt;
            cnt     <= '0;
            acc_sum <= '0;
            acc_sq  <= '0;
            // A start coincident with the final beat re-arms without losing this row.
            if (i_start && (i_beats != '0)) begin
              beats <= i_beats;
              state <= ACC;
            end else begin
              o_err <= i_start;
              state <= IDLE;
            end
          end else if (i_start) begin
            beats <= i_beats;
            if (i_beats == '0) begin
              o_err   <= 1'b1;
              cnt     <= '0;
              acc_sum <= '0;
              acc_sq  <= '0;
              state   <= IDLE;
            end else if (vld_a && (i_beats == {{(CNT_WIDTH-1){1'b0}}, 1'b1})) begin
              o_vld   <= 1'b1;
              o_sum   <= sum_ext;
              o_sqsum <= sq_ext;
              cnt     <= '0;
              acc_sum <= '0;
              acc_sq  <= '0;
              state   <= IDLE;
            end else if (vld_a) begin
              cnt     <= {{(CNT_WIDTH-1){1'b0}}, 1'b1};
              acc_sum <= sum_ext;
              acc_sq  <= sq_ext;
              state   <= ACC;
            end else begin
              cnt     <= '0;
              acc_sum <= '0;
              acc_sq  <= '0;
              state   <= ACC;
            end
          end else if (vld_a) begin
            cnt     <= cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            acc_sum <= sum_nxt;
            acc_sq  <= sq_nxt;
          end else begin
            cnt <= cnt;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ln_stat_acc.sv
// Scoreboard bench for ln_stat_acc: directed rows from the test plan followed by
// randomized traffic, checked against a row-level reference model.
module tb_ln_stat_acc;

  localparam int SW = 26;
  localparam int QW = 42;
  localparam int CW = 8;
  localparam int TL = 5;
  localparam int NCYC = 8192;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   i_start;
  logic [CW-1:0]          i_beats;
  logic                   i_vld;
  logic [SW-1:0]          i_sum;
  logic [QW-1:0]          i_sqsum;
  logic                   o_vld;
  logic signed [SW+CW-1:0] o_sum;
  logic signed [QW+CW-1:0] o_sqsum;
  logic                   o_busy;
  logic                   o_err;
  logic                   o_drop;

  ln_stat_acc #(.SUM_WIDTH(SW), .SQ_WIDTH(QW), .CNT_WIDTH(CW), .TREE_LAT(TL)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_beats(i_beats), .i_vld(i_vld),
    .i_sum(i_sum), .i_sqsum(i_sqsum), .o_vld(o_vld), .o_sum(o_sum),
    .o_sqsum(o_sqsum), .o_busy(o_busy), .o_err(o_err), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected output events, kind 0 = row totals, 1 = err, 2 = drop.
  typedef struct {
    int     cyc;
    int     kind;
    longint s;
    longint q;
  } ev_t;
  ev_t evq[$];

  int checks = 0;
  int errors = 0;

  bit     lnch    [NCYC];
  longint dsum    [NCYC];
  longint dsq     [NCYC];
  bit     exp_ok  [NCYC];
  bit     exp_busy[NCYC];
  longint exp_hs  [NCYC];
  longint exp_hq  [NCYC];

  // Row-level reference state
  int     last_rst = -100;
  bit     armed = 1'b0;
  int     need = 0;
  int     got = 0;
  longint tot_s = 0;
  longint tot_q = 0;
  longint held_s = 0;
  longint held_q = 0;

  function automatic void push(int c, int k, longint s, longint q);
    ev_t e;
    e.cyc = c; e.kind = k; e.s = s; e.q = q;
    evq.push_back(e);
  endfunction

  function automatic void emit_row(int c, longint s, longint q);
    push(c, 0, s, q);
    held_s = s;
    held_q = q;
  endfunction

  task automatic step(input bit r, input bit st, input int b, input bit v,
                      input longint s, input longint q);
    int n;
    bit va;
    bit fin;
    longint as_v, aq_v;
    @(posedge clk);
    #1;
    n = cyc;
    rst = r; i_start = st; i_beats = b[CW-1:0]; i_vld = v;
    lnch[n] = v;
    if (v) begin
      dsum[n+TL] = s;
      dsq[n+TL]  = q;
    end
    if (n >= TL && lnch[n-TL]) begin
      i_sum   = dsum[n][SW-1:0];
      i_sqsum = dsq[n][QW-1:0];
    end else begin
      i_sum   = SW'($urandom());
      i_sqsum = QW'({$urandom(), $urandom()});
    end
    as_v = dsum[n];
    aq_v = dsq[n];
    va = !r && n >= TL && lnch[n-TL] && (n - TL > last_rst);
    if (r) begin
      last_rst = n;
      armed = 1'b0;
      held_s = 0;
      held_q = 0;
    end else if (!armed) begin
      if (st) begin
        if (b != 0) begin
          armed = 1'b1; need = b; got = 0; tot_s = 0; tot_q = 0;
        end else push(n + 1, 1, 0, 0);
      end
      if (va) push(n + 1, 2, 0, 0);
    end else begin
      fin = va && (got == need - 1);
      if (fin) begin
        emit_row(n + 1, tot_s + as_v, tot_q + aq_v);
        armed = 1'b0;
        if (st) begin
          if (b != 0) begin
            armed = 1'b1; need = b; got = 0; tot_s = 0; tot_q = 0;
          end else push(n + 1, 1, 0, 0);
        end
      end else if (st) begin
        if (b == 0) begin
          push(n + 1, 1, 0, 0);
          armed = 1'b0;
        end else begin
          armed = 1'b1; need = b; got = 0; tot_s = 0; tot_q = 0;
          if (va) begin
            got = 1; tot_s = as_v; tot_q = aq_v;
            if (need == 1) begin
              emit_row(n + 1, tot_s, tot_q);
              armed = 1'b0;
            end
          end
        end
      end else if (va) begin
        got++;
        tot_s += as_v;
        tot_q += aq_v;
      end
    end
    exp_ok[n+1]   = 1'b1;
    exp_busy[n+1] = armed;
    exp_hs[n+1]   = held_s;
    exp_hq[n+1]   = held_q;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic beat(input longint s, input longint q);
    step(1'b0, 1'b0, 0, 1'b1, s, q);
  endtask

  task automatic check_ev(input int k, input logic act, input string nm);
    bit e;
    ev_t ev;
    e = (evq.size() > 0) && (evq[0].cyc == cyc) && (evq[0].kind == k);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, e);
    end
    if (e) begin
      ev = evq.pop_front();
      if (k == 0) begin
        checks++;
        if (longint'(o_sum) != ev.s || longint'(o_sqsum) != ev.q) begin
          errors++;
          $display("FAIL row_totals cycle %0d: got sum %0d sq %0d expected sum %0d sq %0d",
                   cyc, o_sum, o_sqsum, ev.s, ev.q);
        end
      end
    end
  endtask

  // Monitor: compares pulses and held outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_ok[cyc]) begin
      check_ev(0, o_vld, "o_vld");
      check_ev(1, o_err, "o_err");
      check_ev(2, o_drop, "o_drop");
      checks++;
      if (o_busy !== exp_busy[cyc]) begin
        errors++;
        $display("FAIL o_busy cycle %0d: got %b expected %b", cyc, o_busy, exp_busy[cyc]);
      end
      checks++;
      if (longint'(o_sum) != exp_hs[cyc] || longint'(o_sqsum) != exp_hq[cyc]) begin
        errors++;
        $display("FAIL held_outputs cycle %0d: got sum %0d sq %0d expected sum %0d sq %0d",
                 cyc, o_sum, o_sqsum, exp_hs[cyc], exp_hq[cyc]);
      end
    end
  end

  initial begin
    logic signed [SW-1:0] rs;
    logic signed [QW-1:0] rq;
    rst = 1'b1; i_start = 1'b0; i_beats = '0; i_vld = 1'b0; i_sum = '0; i_sqsum = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    idle(2);

    // Basic 4-beat row
    step(1'b0, 1'b1, 4, 1'b0, 0, 0);
    beat(10, 100); beat(-3, 9); beat(7, 49); beat(100, 10000);
    idle(8);

    // Gapped beats at the most negative tree value
    step(1'b0, 1'b1, 3, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      beat(-33554432, 0);
      idle(2);
    end
    idle(8);

    // Back-to-back: start coincides with the final aligned beat
    step(1'b0, 1'b1, 2, 1'b0, 0, 0);
    beat(5, 25); beat(6, 36); beat(-1, 1);
    idle(3);
    step(1'b0, 1'b1, 1, 1'b0, 0, 0);
    idle(8);

    // Abort after two aligned beats
    step(1'b0, 1'b1, 4, 1'b0, 0, 0);
    beat(20, 400); beat(30, 900);
    idle(5);
    step(1'b0, 1'b1, 2, 1'b0, 0, 0);
    beat(1, 1); beat(2, 4);
    idle(8);

    // Zero-beat start and a beat arriving while idle
    step(1'b0, 1'b1, 0, 1'b0, 0, 0);
    idle(2);
    beat(77, 5929);
    idle(8);

    // Reset mid-row with valids still in flight
    step(1'b0, 1'b1, 4, 1'b0, 0, 0);
    beat(1, 1); beat(2, 4); beat(3, 9); beat(4, 16);
    idle(2);
    beat(5, 25);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
    idle(8);
    step(1'b0, 1'b1, 1, 1'b0, 0, 0);
    beat(9, 81);
    idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs = SW'($urandom());
      rq = QW'({$urandom(), $urandom()});
      step(($urandom_range(0, 399) == 0),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6),
           ($urandom_range(0, 9) < 4),
           longint'(rs), longint'(rq));
    end
    idle(12);

    @(negedge clk);
    #1;
    checks++;
    if (evq.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d left expected 0", evq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ln_stat_acc.md
Name: ln_stat_acc

Overview:
- Row-statistics accumulator for the LayerNorm path.
- Sits directly downstream of two channel-reduction adder trees: one reduces x, the other reduces x^2.
- Each cycle it takes the tree outputs for one channel group (beat) and accumulates them across a configurable number of beats per row.
- At row end it emits the row totals Σx and Σx² to the mean/variance stage.
- The trees carry no valid signal, so this block re-times the launch valid through its own delay line.

Parameters:
- SUM_WIDTH, 26, width of the signed Σx tree output.
- SQ_WIDTH, 42, width of the signed Σx² tree output.
- CNT_WIDTH, 8, width of the beat counter; max beats per row is 2^CNT_WIDTH-1.
- TREE_LAT, 5, adder-tree latency in cycles, from tree input to tree output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle pulse; loads i_beats and arms a new row.
- i_beats  in  CNT_WIDTH  beats per row; sampled on i_start.
- i_vld  in  1  valid, launched in the same cycle the beat's data enters the trees.
- i_sum  in  SUM_WIDTH  Σx tree output, signed.
- i_sqsum  in  SQ_WIDTH  Σx² tree output, signed.
- o_vld  out  1  one-cycle pulse; row totals are valid.
- o_sum  out  SUM_WIDTH+CNT_WIDTH  row Σx, signed.
- o_sqsum  out  SQ_WIDTH+CNT_WIDTH  row Σx², signed.
- o_busy  out  1  high while a row is armed (state ACC).
- o_err  out  1  one-cycle pulse; i_start was rejected because i_beats==0.
- o_drop  out  1  one-cycle pulse; an aligned beat arrived in IDLE and was discarded.

Behaviour:
- Reset: on rst=1 at a clk edge, every output and accumulator goes to 0, the beat counter goes to 0, the delay line clears, and state goes to IDLE. Reset mid-row discards all partial totals and in-flight valids.
- Alignment: i_vld passes through a TREE_LAT-deep shift register to form vld_a. vld_a is coincident with the matching i_sum/i_sqsum. Data is never delayed.
- State machine: two states.
  - IDLE: on i_start with i_beats!=0, clear acc_sum, acc_sq and cnt; latch beats; go to ACC. On i_start with i_beats==0, pulse o_err next cycle and stay in IDLE. vld_a in IDLE pulses o_drop next cycle and the beat is discarded.
  - ACC: on each vld_a, acc_sum += sign-extended i_sum, acc_sq += sign-extended i_sqsum, cnt += 1.
- Row completion: when the vld_a beat has cnt==beats-1, the next cycle presents o_vld=1 with o_sum/o_sqsum equal to totals including that beat, and the state returns to IDLE.
- Latency: o_vld rises TREE_LAT+1 cycles after the i_vld of the last beat.
- Outputs: o_sum and o_sqsum hold until the next o_vld or reset. o_vld is never asserted for two consecutive cycles unless rows complete back-to-back.
- Width: accumulators are SUM_WIDTH+CNT_WIDTH and SQ_WIDTH+CNT_WIDTH wide and use signed arithmetic, so overflow is impossible for beats ≤ 2^CNT_WIDTH-1.
- i_start in ACC on a non-final beat: the current row is aborted with no o_vld; accumulators and cnt clear; new beats are latched (an o_err rule applies if i_beats==0, and the state then goes to IDLE). A vld_a in that same cycle counts as the first beat of the new row.
- i_start in the same cycle as the final vld_a: the old row completes normally (o_vld next cycle), and the new row arms with accumulators cleared. A vld_a in the next cycle belongs to the new row.
- beats==1: the single vld_a completes the row; o_vld follows one cycle later.
- o_busy equals (state==ACC).

Test Plan:
- Basic row: reset, i_start with i_beats=4; i_vld on 4 consecutive cycles; aligned i_sum = 10,-3,7,100 and i_sqsum = 100,9,49,10000 → one o_vld pulse 6 cycles after the last i_vld, with o_sum=114 and o_sqsum=10158; o_busy falls in the same cycle.
- Gapped beats plus extremes: i_beats=3 with 2 idle cycles between i_vld; i_sum = -2^25 three times → o_sum = -3·2^25 exactly (no wrap); o_vld pulses exactly once.
- Back-to-back rows: i_start coincident with the final aligned beat of a 2-beat row (sums 5,6), then a 1-beat row (sum -1) → o_vld with o_sum=11, followed by o_vld with o_sum=-1; no cross-contamination between rows.
- Abort: i_beats=4; after 2 beats (sum 50), i_start with i_beats=2, then beats 1,2 → only one o_vld, with o_sum=3.
- Errors: i_start with i_beats=0 → o_err for 1 cycle and o_busy stays 0. Aligned beat while IDLE → o_drop for 1 cycle and outputs unchanged.
- Reset mid-row: rst after 2 of 4 beats with 3 i_vld still in flight → all outputs 0, no o_vld and no o_drop from the flushed valids; a following 1-beat row with sum 9 produces o_sum=9.
